// File: rtl/cia_tod_ctrl_if.sv
// Register and TOD-pin bundle between the CIA decoder and the TOD block.
// master = register decoder side, slave = cia_tod_ctrl.
interface cia_tod_ctrl_if;
    logic       tod_tick;
    logic       todin_50;
    logic       alarm_sel;
    logic       we;
    logic       re;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq_alarm;

    modport master (
        output tod_tick, todin_50, alarm_sel, we, re, addr, wdata,
        input  rdata, irq_alarm
    );

    modport slave (
        input  tod_tick, todin_50, alarm_sel, we, re, addr, wdata,
        output rdata, irq_alarm
    );
endinterface

// File: rtl/cia_tod_ctrl.sv
// CIA time-of-day controller: prescaler, BCD clock chain, read latch, alarm.
// Optional alarm logic is enabled by defining CIA_TOD_ALARM_EN.
module cia_tod_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    cia_tod_ctrl_if.slave  bus
);
    typedef struct packed {
        logic [7:0] hrs;
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] ten;
    } tod_t;

    tod_t       r_tod;
    tod_t       r_shd;
    tod_t       w_step;
    tod_t       w_tod_n;
    tod_t       w_src;
    logic [2:0] r_pre;
    logic       r_halt;
    logic       r_lat;
    logic       r_irq;
    logic       w_run;
    logic       w_wrap;
    logic       w_twr;
    logic       w_c0;
    logic [2:0] w_lim;
    logic [7:0] w_wd;
    logic [8:0] w_sec_i;
    logic [8:0] w_min_i;

    // BCD 00-59 increment; bit 8 is the carry out
    function automatic logic [8:0] inc60(input logic [7:0] v);
        if (v[3:0] != 4'h9) return {1'b0, v[7:4], v[3:0] + 4'h1};
        if (v[6:4] == 3'h5) return 9'h100;
        return {1'b0, 1'b0, v[6:4] + 3'h1, 4'h0};
    endfunction

    // 12-hour BCD increment; PM flips only on 11 -> 12
    function automatic logic [7:0] inc_hr(input logic [7:0] h);
        if (h[4:0] == 5'h12) return {h[7], 2'b00, 5'h01};
        if (h[4:0] == 5'h11) return {~h[7], 2'b00, 5'h12};
        if (h[3:0] == 4'h9)  return {h[7], 2'b00, 5'h10};
        return {h[7], 2'b00, h[4:0] + 5'h1};
    endfunction

    assign w_lim   = bus.todin_50 ? 3'd4 : 3'd5;
    assign w_run   = bus.tod_tick && !r_halt;
    assign w_wrap  = w_run && (r_pre >= w_lim);
    assign w_twr   = bus.we && !bus.alarm_sel;
    assign w_c0    = (r_tod.ten[3:0] == 4'h9);
    assign w_sec_i = inc60(r_tod.sec);
    assign w_min_i = inc60(r_tod.min);

    // write data with the per-register storage mask applied
    always_comb begin
        w_wd = 8'h00;
        case (bus.addr)
            2'd0: w_wd = bus.wdata & 8'h0F;
            2'd1: w_wd = bus.wdata & 8'h7F;
            2'd2: w_wd = bus.wdata & 8'h7F;
            2'd3: w_wd = bus.wdata & 8'h9F;
            default: w_wd = 8'h00;
        endcase
    end

    // single-cycle ripple of one step through all digit slices
    always_comb begin
        w_step     = r_tod;
        w_step.ten = w_c0 ? 8'h00 : {4'h0, r_tod.ten[3:0] + 4'h1};
        if (w_c0) begin
            w_step.sec = w_sec_i[7:0];
            if (w_sec_i[8]) begin
                w_step.min = w_min_i[7:0];
                if (w_min_i[8]) w_step.hrs = inc_hr(r_tod.hrs);
            end
        end
    end

    // next live time: a time write cancels a coincident step
    always_comb begin
        w_tod_n = r_tod;
        if (w_twr) begin
            case (bus.addr)
                2'd0: w_tod_n.ten = w_wd;
                2'd1: w_tod_n.sec = w_wd;
                2'd2: w_tod_n.min = w_wd;
                2'd3: w_tod_n.hrs = w_wd;
                default: w_tod_n = r_tod;
            endcase
        end else if (w_wrap) begin
            w_tod_n = w_step;
        end
    end

    // live time, prescaler, halt flag and read latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tod  <= '{hrs: 8'h01, min: 8'h00, sec: 8'h00, ten: 8'h00};
            r_shd  <= '0;
            r_pre  <= 3'd0;
            r_halt <= 1'b1;
            r_lat  <= 1'b0;
        end else begin
            r_tod <= w_tod_n;
            if (w_twr && bus.addr == 2'd0) r_pre <= 3'd0;
            else if (w_run) r_pre <= w_wrap ? 3'd0 : r_pre + 3'd1;
            if (w_twr && bus.addr == 2'd3) r_halt <= 1'b1;
            else if (w_twr && bus.addr == 2'd0) r_halt <= 1'b0;
            if (bus.re && !bus.we) begin
                if (bus.addr == 2'd3 && !r_lat) begin
                    r_shd <= r_tod;
                    r_lat <= 1'b1;
                end else if (bus.addr == 2'd0 && r_lat) begin
                    r_lat <= 1'b0;
                end
            end
        end
    end

    // register read mux, shadow while latched
    always_comb begin
        w_src = r_lat ? r_shd : r_tod;
        case (bus.addr)
            2'd0: bus.rdata = w_src.ten;
            2'd1: bus.rdata = w_src.sec;
            2'd2: bus.rdata = w_src.min;
            2'd3: bus.rdata = w_src.hrs;
            default: bus.rdata = 8'h00;
        endcase
    end

`ifdef CIA_TOD_ALARM_EN
    tod_t r_alm;
    tod_t w_alm_n;
    logic w_awr;

    assign w_awr = bus.we && bus.alarm_sel;

    // next alarm value
    always_comb begin
        w_alm_n = r_alm;
        if (w_awr) begin
            case (bus.addr)
                2'd0: w_alm_n.ten = w_wd;
                2'd1: w_alm_n.sec = w_wd;
                2'd2: w_alm_n.min = w_wd;
                2'd3: w_alm_n.hrs = w_wd;
                default: w_alm_n = r_alm;
            endcase
        end
    end

    // alarm storage and one-shot match pulse after any update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alm <= '0;
            r_irq <= 1'b0;
        end else begin
            r_alm <= w_alm_n;
            r_irq <= (w_twr || w_wrap || w_awr) && (w_tod_n == w_alm_n);
        end
    end
`else
    // no alarm hardware: pulse held low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= 1'b0;
    end
`endif

    assign bus.irq_alarm = r_irq;
endmodule
